// File: rtl/cdc_pkg.sv
// Shared constants for the byte FIFOs bridging the USB CDC and UART paths.
package cdc_pkg;

   localparam int unsigned FIFO_DEPTH = 16;
   localparam int unsigned BYTE_W     = 8;

endpackage : cdc_pkg

// File: rtl/cdc_byte_fifo.sv
// Single-clock first-word-fall-through byte FIFO with occupancy count and sticky overflow.
module cdc_byte_fifo
   import cdc_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH,
   parameter int unsigned WIDTH = BYTE_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clear_i,
   input  logic [WIDTH-1:0]           in_data_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   output logic [WIDTH-1:0]           out_data_o,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [$clog2(DEPTH):0]     level_o,
   output logic                       overflow_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW-1:0]    wr_ptr_nxt, rd_ptr_nxt;
   logic [LW-1:0]    level, level_nxt;
   logic             overflow, overflow_nxt;
   logic             full, empty, wr_en, rd_en;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == LW'(0));

   assign in_ready_o  = !full;
   assign out_valid_o = !empty;
   assign out_data_o  = mem[rd_ptr];
   assign level_o     = level;
   assign overflow_o  = overflow;

   assign wr_en = in_valid_i && in_ready_o;
   assign rd_en = out_valid_o && out_ready_i;

   // Next-state: clear overrides any handshake in the same cycle.
   always_comb begin
      wr_ptr_nxt   = wr_ptr;
      rd_ptr_nxt   = rd_ptr;
      level_nxt    = level;
      overflow_nxt = overflow;
      if (clear_i) begin
         wr_ptr_nxt   = AW'(0);
         rd_ptr_nxt   = AW'(0);
         level_nxt    = LW'(0);
         overflow_nxt = 1'b0;
      end else begin
         if (wr_en) wr_ptr_nxt = wr_ptr + AW'(1);
         if (rd_en) rd_ptr_nxt = rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
         endcase
         if (in_valid_i && full) overflow_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= AW'(0);
         rd_ptr   <= AW'(0);
         level    <= LW'(0);
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nxt;
         rd_ptr   <= rd_ptr_nxt;
         level    <= level_nxt;
         overflow <= overflow_nxt;
      end
   end

   // Storage carries no reset; validity is tracked by level alone.
   always_ff @(posedge clk) begin
      if (wr_en && !clear_i) mem[wr_ptr] <= in_data_i;
   end

endmodule : cdc_byte_fifo

// File: tb/tb_cdc_byte_fifo.sv
// Scoreboard bench for cdc_byte_fifo: a reference level/overflow model plus a data queue.
module tb_cdc_byte_fifo;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned WIDTH = 8;
   localparam int unsigned LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             clear_i;
   logic [WIDTH-1:0] in_data_i;
   logic             in_valid_i;
   logic             in_ready_o;
   logic [WIDTH-1:0] out_data_o;
   logic             out_valid_o;
   logic             out_ready_i;
   logic [LW-1:0]    level_o;
   logic             overflow_o;

   cdc_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (clear_i),
      .in_data_i   (in_data_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .out_data_o  (out_data_o),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .level_o     (level_o),
      .overflow_o  (overflow_o)
   );

   always #10 clk = ~clk;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   logic [7:0]  sb_q[$];
   int unsigned m_level = 0;
   logic        m_ovf   = 1'b0;
   logic        lvl_ok;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One clock: drive at negedge, check state, advance model for the coming posedge.
   task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic clr);
      logic wr, rd;
      @(negedge clk);
      in_valid_i  = v;
      in_data_i   = d;
      out_ready_i = r;
      clear_i     = clr;
      #1;
      chk("level", 32'(level_o), 32'(m_level));
      chk("in_ready", 32'(in_ready_o), 32'(m_level < DEPTH));
      chk("out_valid", 32'(out_valid_o), 32'(m_level != 0));
      chk("overflow", 32'(overflow_o), 32'(m_ovf));
      wr = v && (m_level < DEPTH);
      rd = r && (m_level != 0);
      if (rd && !clr) begin
         chk("out_data", 32'(out_data_o), 32'(sb_q[0]));
         void'(sb_q.pop_front());
      end
      if (clr) begin
         sb_q.delete();
         m_level = 0;
         m_ovf   = 1'b0;
      end else begin
         if (v && m_level == DEPTH) m_ovf = 1'b1;
         if (wr) sb_q.push_back(d);
         m_level = m_level + 32'(wr) - 32'(rd);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * DEPTH && m_level != 0; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      rst_n       = 1'b0;
      clear_i     = 1'b0;
      in_data_i   = '0;
      in_valid_i  = 1'b0;
      out_ready_i = 1'b0;
      #1;
      chk("rst_level", 32'(level_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o), 32'd1);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_overflow", 32'(overflow_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill 0x01..0x10 without reading
      for (int i = 1; i <= 16; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("full_level", 32'(level_o), 32'd16);
      // Write 0xAA while full: dropped, overflow sticks
      drive(1'b1, 8'hAA, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("ovf_set", 32'(overflow_o), 32'd1);
      drain();

      // Read of empty FIFO is ignored
      drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b0, 8'h00, 1'b1, 1'b0);

      // Single byte fall-through latency
      drive(1'b1, 8'h5A, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("fwft_data", 32'(out_data_o), 32'h5A);
      drain();

      // Streaming 100 bytes at one per cycle; level holds at 1
      lvl_ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, 8'(i), 1'b1, 1'b0);
         if (i > 0 && level_o != LW'(1)) lvl_ok = 1'b0;
      end
      chk("stream_level_one", 32'(lvl_ok), 32'd1);
      drain();

      // Clear at level 5 with overflow set, with concurrent read and write
      for (int i = 0; i < 17; i++) drive(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) drive(1'b0, 8'h00, 1'b1, 1'b0);
      drive(1'b1, 8'hC3, 1'b1, 1'b1);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("clr_level", 32'(level_o), 32'd0);
      chk("clr_out_valid", 32'(out_valid_o), 32'd0);

      // Random mix of traffic
      for (int i = 0; i < 200; i++)
         drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0), 1'b0);
      drain();

      // Async reset mid-burst at level 7
      for (int i = 0; i < 7; i++) drive(1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      @(posedge clk);
      #3;
      in_valid_i = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("arst_level", 32'(level_o), 32'd0);
      chk("arst_out_valid", 32'(out_valid_o), 32'd0);
      chk("arst_in_ready", 32'(in_ready_o), 32'd1);
      chk("arst_overflow", 32'(overflow_o), 32'd0);
      sb_q.delete();
      m_level = 0;
      m_ovf   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 8'hE1, 1'b0, 1'b0);
      drive(1'b1, 8'hE2, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_rst_head", 32'(out_data_o), 32'hE1);
      drain();
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_cdc_byte_fifo

// File: doc/cdc_byte_fifo.md
CDC_BYTE_FIFO -- requirements
Module: cdc_byte_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning FIFO depth in bytes; legal values are powers of two, 4..64.
REQ-002 The block SHALL have parameter WIDTH, default 8, meaning data width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock (48 MHz system clock).
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port clear_i, input, 1 bit: synchronous flush.
REQ-006 The block SHALL have port in_data_i, input, WIDTH bits: write data (from usb_cdc out_data_o or uart_rx data).
REQ-007 The block SHALL have port in_valid_i, input, 1 bit: write request.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit: space available.
REQ-009 The block SHALL have port out_data_o, output, WIDTH bits: head-of-FIFO data.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit: head data valid.
REQ-011 The block SHALL have port out_ready_i, input, 1 bit: consumer accepts (e.g. ~uart_tx_busy or usb_cdc in_ready_o).
REQ-012 The block SHALL have port level_o, output, log2(DEPTH)+1 bits: current occupancy.
REQ-013 The block SHALL have port overflow_o, output, 1 bit: sticky flag, set on a write attempt while full.

Function
REQ-014 The block SHALL accept a write in a cycle when in_valid_i && in_ready_o, and SHALL complete a read in a cycle when out_valid_o && out_ready_i.
REQ-015 The block SHALL drive in_ready_o = (level < DEPTH) and out_valid_o = (level != 0), combinationally from registered state.
REQ-016 The block SHALL be first-word-fall-through: out_data_o shows the oldest entry whenever out_valid_o=1.
REQ-017 Write-to-read latency SHALL be one cycle: a byte written into an empty FIFO at edge N gives out_valid_o=1 after edge N.
REQ-018 Simultaneous read and write SHALL leave level unchanged; this SHALL be allowed when full (the read frees the slot, so in_ready_o stays low and the write is refused) and when empty (no read occurs; the write is accepted).
REQ-019 The read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH with no gap or skip.
REQ-020 level_o SHALL equal writes minus reads, range 0..DEPTH, and SHALL never exceed DEPTH or go below 0.
REQ-021 When in_valid_i=1 and level=DEPTH, the write SHALL be dropped with data unchanged, and overflow_o SHALL be set at the next edge.
REQ-022 overflow_o SHALL remain set until reset or clear_i.
REQ-023 A read attempt (out_ready_i=1) when empty SHALL be ignored, with no pointer movement.
REQ-024 clear_i=1 SHALL, at the next edge, zero both pointers, level_o and overflow_o; any read or write in that same cycle SHALL be discarded (clear wins).
REQ-025 out_data_o SHALL be don't-care while out_valid_o=0; the bench shall not check it.
REQ-026 The storage array SHALL be unreset registers; only pointers, level and flags are reset.

Reset
REQ-027 Reset SHALL be asynchronous on rst_n low and SHALL take effect without a clock.
REQ-028 While in reset and after reset: pointers=0, level_o=0, out_valid_o=0, in_ready_o=1, overflow_o=0.
REQ-029 Reset asserted mid-transfer SHALL discard all contents; the first write after deassertion SHALL be the first byte read.

Structure
REQ-030 Shared package cdc_pkg SHALL hold the default FIFO depth constant and the UART/USB byte width constant for reuse by tt_um top-level glue.
REQ-031 The block SHALL be single-module; no sub-module is needed, and the storage is an inferred register array.
REQ-032 Two instances SHALL be placed at top level: USB-out -> UART-tx path, and UART-rx -> USB-in path.

Verification
REQ-033 Reset then write 0x01..0x10 with out_ready_i=0 -> level_o=16, in_ready_o=0, overflow_o=0; read all -> 0x01..0x10 in order.
REQ-034 At full, hold in_valid_i=1 with data 0xAA for one cycle -> overflow_o=1 next cycle, level_o=16, and 0xAA is never read out.
REQ-035 Continuous write and read at one byte per cycle for 100 bytes (0x00..0x63) -> level_o stays at 1 after the first write, output order is preserved, and pointers wrap at least six times.
REQ-036 Empty FIFO, write 0x5A -> out_valid_o=1 and out_data_o=0x5A in the following cycle.
REQ-037 Level 5 with overflow set, pulse clear_i while in_valid_i=1 and out_ready_i=1 -> level_o=0, overflow_o=0, out_valid_o=0 next cycle.
REQ-038 Assert rst_n=0 asynchronously mid-burst at level 7 -> outputs take reset values before the next clk edge.
